// File: rtl/seq_gen_pkg.sv
// Shared constants and helpers for the multi-mode sequence generator.
package seq_gen_pkg;

  localparam int unsigned MaxWidth = 16;

  localparam logic [1:0] MODE_JOHNSON = 2'd0;
  localparam logic [1:0] MODE_RING    = 2'd1;
  localparam logic [1:0] MODE_LFSR    = 2'd2;
  localparam logic [1:0] MODE_BINARY  = 2'd3;

  // Fibonacci tap masks for a right-shifting register: the new MSB is the XOR of q & mask.
  // Bit 0 is always tapped; bit (n-k) is tapped for each x^k term of the polynomial.
  function automatic logic [MaxWidth-1:0] lfsr_taps(input int unsigned width);
    logic [MaxWidth-1:0] taps;
    taps = '0;
    unique case (width)
      3:       taps = 16'b0000_0000_0000_0011; // x^3+x^2+1
      4:       taps = 16'b0000_0000_0000_0011; // x^4+x^3+1
      5:       taps = 16'b0000_0000_0000_0101; // x^5+x^3+1
      6:       taps = 16'b0000_0000_0000_0011; // x^6+x^5+1
      7:       taps = 16'b0000_0000_0000_0011; // x^7+x^6+1
      8:       taps = 16'b0000_0000_0001_1101; // x^8+x^6+x^5+x^4+1
      9:       taps = 16'b0000_0000_0001_0001; // x^9+x^5+1
      10:      taps = 16'b0000_0000_0000_1001; // x^10+x^7+1
      11:      taps = 16'b0000_0000_0000_0101; // x^11+x^9+1
      12:      taps = 16'b0000_1001_0100_0001; // x^12+x^6+x^4+x+1
      13:      taps = 16'b0001_0110_0000_0001; // x^13+x^4+x^3+x+1
      14:      taps = 16'b0010_1010_0000_0001; // x^14+x^5+x^3+x+1
      15:      taps = 16'b0000_0000_0000_0011; // x^15+x^14+1
      16:      taps = 16'b0001_0000_0000_1011; // x^16+x^15+x^13+x^4+1
      default: taps = '0;
    endcase
    return taps;
  endfunction

  // State the sequence returns to once per period.
  function automatic logic [MaxWidth-1:0] home_state(input logic [1:0] mode, input logic dir,
                                                     input int unsigned width);
    logic [31:0] ones;
    ones = (32'd1 << width) - 32'd1;
    unique case (mode)
      MODE_JOHNSON: return '0;
      MODE_RING:    return 16'd1;
      MODE_LFSR:    return 16'd1;
      default:      return dir ? ones[MaxWidth-1:0] : '0;
    endcase
  endfunction

endpackage

// File: rtl/seq_gen_next.sv
// Combinational next-state and home-state compare for all four sequence modes.
module seq_gen_next
  import seq_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [1:0]       mode_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] next_q_o,
  output logic             is_home_o
);

  localparam logic [WIDTH-1:0] Taps = WIDTH'(lfsr_taps(WIDTH));

  logic [WIDTH-1:0] home;
  assign home = WIDTH'(home_state(mode_i, dir_i, WIDTH));

  // Step function per mode; zero escape applies only to ring and LFSR.
  always_comb begin
    next_q_o = q_i;
    unique case (mode_i)
      MODE_JOHNSON: begin
        next_q_o = dir_i ? {q_i[WIDTH-2:0], ~q_i[WIDTH-1]} : {~q_i[0], q_i[WIDTH-1:1]};
      end
      MODE_RING: begin
        if (q_i == '0) next_q_o = WIDTH'(1);
        else next_q_o = dir_i ? {q_i[WIDTH-2:0], q_i[WIDTH-1]} : {q_i[0], q_i[WIDTH-1:1]};
      end
      MODE_LFSR: begin
        if (q_i == '0) next_q_o = WIDTH'(1);
        else next_q_o = {^(q_i & Taps), q_i[WIDTH-1:1]};
      end
      default: begin
        next_q_o = dir_i ? (q_i - WIDTH'(1)) : (q_i + WIDTH'(1));
      end
    endcase
  end

  assign is_home_o = (next_q_o == home);

endmodule

// File: rtl/seq_gen.sv
// Multi-mode sequence generator: state register, rst/load/en priority and wrap strobe.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [1:0]       mode_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] q_o,
  output logic             wrap_o
);

  if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
    $error("seq_gen: WIDTH must be in 3..16");
  end

  logic [WIDTH-1:0] q_q, q_d, next_q;
  logic             wrap_q, wrap_d, is_home;

  seq_gen_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .q_i      (q_q),
    .mode_i   (mode_i),
    .dir_i    (dir_i),
    .next_q_o (next_q),
    .is_home_o(is_home)
  );

  // Load beats step; wrap only follows a real step that lands on home.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      q_d    = next_q;
      wrap_d = is_home;
    end
  end

  // State and strobe registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q_o    = q_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen at WIDTH=4: directed plan steps plus random traffic
// checked against an arithmetic reference model.
module tb_seq_gen;

  localparam int W = 4;
  localparam int AllOnes = (1 << W) - 1;
  localparam int Taps = 4'b0011;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [1:0]   mode = 2'd0;
  logic         dir = 1'b0;
  logic [W-1:0] q;
  logic         wrap;

  int n_cmp = 0;
  int n_err = 0;
  int m_q = 0;
  int m_wrap = 0;

  seq_gen #(
    .WIDTH(W)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .load_i    (load),
    .load_val_i(load_val),
    .mode_i    (mode),
    .dir_i     (dir),
    .q_o       (q),
    .wrap_o    (wrap)
  );

  always #5 clk = ~clk;

  function automatic int ref_next(int s, int m, bit d);
    int fb;
    case (m)
      0: return d ? (((s << 1) & AllOnes) | (((s >> (W - 1)) & 1) ^ 1))
                  : ((s >> 1) | (((s & 1) ^ 1) << (W - 1)));
      1: begin
        if (s == 0) return 1;
        return d ? (((s << 1) & AllOnes) | ((s >> (W - 1)) & 1))
                 : ((s >> 1) | ((s & 1) << (W - 1)));
      end
      2: begin
        if (s == 0) return 1;
        fb = $countones(s & Taps) % 2;
        return (s >> 1) | (fb << (W - 1));
      end
      default: return d ? ((s + AllOnes) & AllOnes) : ((s + 1) & AllOnes);
    endcase
  endfunction

  function automatic int ref_home(int m, bit d);
    if (m == 0) return 0;
    if (m == 3) return d ? AllOnes : 0;
    return 1;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare q and wrap against it.
  task automatic step(bit r, bit l, bit e, logic [W-1:0] lv, logic [1:0] m, bit d);
    int nq;
    rst = r; load = l; en = e; load_val = lv; mode = m; dir = d;
    @(posedge clk);
    #1;
    if (r) begin
      m_q = 0; m_wrap = 0;
    end else if (l) begin
      m_q = int'(lv); m_wrap = 0;
    end else if (e) begin
      nq = ref_next(m_q, int'(m), d);
      m_wrap = (nq == ref_home(int'(m), d)) ? 1 : 0;
      m_q = nq;
    end else begin
      m_wrap = 0;
    end
    chk("model_q", {28'b0, q}, m_q);
    chk("model_wrap", {31'b0, wrap}, m_wrap);
  endtask

  initial begin : main
    int jexp[8] = '{8, 12, 14, 15, 7, 3, 1, 0};
    int rexp[5] = '{1, 2, 4, 8, 1};
    bit seen[16];
    int distinct;
    bit saw_zero;

    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0);
    chk("reset_q", {28'b0, q}, 0);
    chk("reset_wrap", {31'b0, wrap}, 0);

    // Johnson right
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0, 0, 0);
      chk("johnson_q", {28'b0, q}, jexp[i]);
      chk("johnson_wrap", {31'b0, wrap}, (i == 7) ? 1 : 0);
    end

    // Ring left out of reset
    step(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 1, 1);
      chk("ring_q", {28'b0, q}, rexp[i]);
      chk("ring_wrap", {31'b0, wrap}, (i == 0 || i == 4) ? 1 : 0);
    end

    // LFSR full period
    step(1, 0, 0, 0, 2, 0);
    foreach (seen[k]) seen[k] = 1'b0;
    distinct = 0;
    saw_zero = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 1, 0, 2, 0);
      if (q == 0) saw_zero = 1'b1;
      if (i <= 15 && !seen[q]) begin
        seen[q] = 1'b1;
        distinct++;
      end
      if (i == 1 || i == 16) begin
        chk("lfsr_home_q", {28'b0, q}, 1);
        chk("lfsr_home_wrap", {31'b0, wrap}, 1);
      end
    end
    chk("lfsr_distinct", distinct, 15);
    chk("lfsr_never_zero", {31'b0, saw_zero}, 0);

    // Binary up across wrap, then down
    step(0, 1, 0, 4'b1110, 3, 0);
    chk("bin_load_q", {28'b0, q}, 4'b1110);
    step(0, 0, 1, 0, 3, 0);
    chk("bin_up1_q", {28'b0, q}, 4'b1111);
    chk("bin_up1_wrap", {31'b0, wrap}, 0);
    step(0, 0, 1, 0, 3, 0);
    chk("bin_up2_q", {28'b0, q}, 4'b0000);
    chk("bin_up2_wrap", {31'b0, wrap}, 1);
    step(0, 0, 1, 0, 3, 1);
    chk("bin_dn_q", {28'b0, q}, 4'b1111);
    chk("bin_dn_wrap", {31'b0, wrap}, 1);

    // Load beats enable; reset beats load
    step(0, 1, 1, 4'b1010, 1, 0);
    chk("load_en_q", {28'b0, q}, 4'b1010);
    chk("load_en_wrap", {31'b0, wrap}, 0);
    step(1, 1, 1, 4'b1010, 1, 0);
    chk("rst_load_q", {28'b0, q}, 0);

    // Mode switch mid-sequence, then hold
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("sw_johnson_q", {28'b0, q}, 4'b1100);
    step(0, 0, 1, 0, 1, 0);
    chk("sw_ring_q", {28'b0, q}, 4'b0110);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 0);
      chk("hold_q", {28'b0, q}, 4'b0110);
      chk("hold_wrap", {31'b0, wrap}, 0);
    end

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0), 4'($urandom), 2'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
